// File: rtl/profile_pkg.sv
// Shared opcode, state and width definitions for the profiling-window custom instruction.
package profile_pkg;

  localparam int CNT_W_DEF = 32;

  localparam logic [2:0] OP_READ   = 3'd0;
  localparam logic [2:0] OP_SETLEN = 3'd1;
  localparam logic [2:0] OP_GO     = 3'd2;
  localparam logic [2:0] OP_STATUS = 3'd3;
  localparam logic [2:0] OP_ABORT  = 3'd4;
  localparam logic [2:0] OP_WAIT   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/profile_counter.sv
// Wrapping event counter with synchronous clear; clear wins over increment.
module profile_counter
  import profile_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     value <= '0;
    else if (clear) value <= '0;
    else if (inc)   value <= value + CNT_W'(1);
  end

endmodule

// File: rtl/profile_window_ci.sv
// Custom-instruction controller: runs a bounded window over four masked event counters.
// done pulses one cycle after accept, except WAIT in RUN which completes when the window ends.
module profile_window_ci
  import profile_pkg::*;
#(
  parameter logic [7:0] customId = 8'h00,
  parameter int         CNT_W    = CNT_W_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic        stall,
  input  logic        busIdle,
  output logic        done,
  output logic [31:0] result
);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   len, remain;
  logic [CNT_W-1:0]   cnt [4];
  logic [3:0]         mask, ev, inc;
  logic               aborted, wait_pend, wait_set;
  logic               acc, go, abort, tick, win_end;
  logic               done_d;
  logic [31:0]        result_d;
  logic [2:0]         op;
  logic               unused_bits;

  assign op          = valueA[2:0];
  assign unused_bits = ^valueA[31:3];

  // While a WAIT is outstanding only ABORT is acted upon.
  assign acc     = start && (ciN == customId) && (!wait_pend || op == OP_ABORT);
  assign go      = acc && (op == OP_GO);
  assign abort   = acc && (op == OP_ABORT) && (state == ST_RUN);
  assign tick    = (state == ST_RUN) && !go && !abort;
  assign win_end = tick && (remain == CNT_W'(1));
  assign ev      = {stall & ~busIdle, busIdle, stall, 1'b1};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (go)                state_nxt = (len == '0) ? ST_FIN : ST_RUN;
    else if (abort || win_end) state_nxt = ST_FIN;
  end

  always_comb begin
    inc      = {4{tick}} & mask & ev;
    done_d   = 1'b0;
    result_d = '0;
    wait_set = 1'b0;
    if (wait_pend) begin
      if (abort) begin
        done_d   = 1'b1;
        result_d = 32'(cnt[0]);
      end else if (win_end) begin
        done_d   = 1'b1;
        result_d = 32'(cnt[0] + CNT_W'(inc[0]));
      end
    end else if (acc) begin
      done_d = 1'b1;
      case (op)
        OP_READ:   result_d = 32'(cnt[valueB[1:0]]);
        OP_SETLEN: result_d = 32'(len);
        OP_GO:     result_d = '0;
        OP_STATUS: result_d = {state, aborted, 29'b0};
        OP_ABORT:  result_d = 32'(remain);
        OP_WAIT: begin
          // A WAIT landing on the final window cycle completes immediately with the last count.
          if (win_end) begin
            result_d = 32'(cnt[0] + CNT_W'(inc[0]));
          end else if (state == ST_RUN) begin
            done_d   = 1'b0;
            wait_set = 1'b1;
          end else begin
            result_d = 32'(cnt[0]);
          end
        end
        default:   result_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len       <= '0;
      remain    <= '0;
      mask      <= '0;
      aborted   <= 1'b0;
      wait_pend <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done   <= done_d;
      result <= result_d;
      if (acc && op == OP_SETLEN) len <= CNT_W'(valueB);
      if (go) begin
        mask    <= valueB[3:0];
        remain  <= len;
        aborted <= 1'b0;
      end else if (tick) begin
        remain  <= remain - CNT_W'(1);
      end
      if (abort) aborted <= 1'b1;
      if (wait_set)             wait_pend <= 1'b1;
      else if (wait_pend && done_d) wait_pend <= 1'b0;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    profile_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock (clock),
      .reset (reset),
      .clear (go),
      .inc   (inc[i]),
      .value (cnt[i])
    );
  end

endmodule

// File: tb/tb_profile_window_ci.sv
// Scoreboard bench: stimulus pushes expected CI results, a negedge monitor pops on each done.
module tb_profile_window_ci;

  localparam logic [7:0] ID = 8'h2A;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ciN = 8'h00;
  logic [31:0] valueA = '0;
  logic [31:0] valueB = '0;
  logic        stall = 1'b0;
  logic        busIdle = 1'b0;
  logic        done;
  logic [31:0] result;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] exp_q [$];

  profile_window_ci #(.customId(ID), .CNT_W(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .ciN     (ciN),
    .valueA  (valueA),
    .valueB  (valueB),
    .stall   (stall),
    .busIdle (busIdle),
    .done    (done),
    .result  (result)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got result %h with nothing expected (t=%0t)", result, $time);
      end else begin
        chk("ci_result", result, exp_q.pop_front());
      end
    end else begin
      chk("result_zero_when_idle", result, 32'h0);
    end
  end

  task automatic ci(input logic [7:0] id, input logic [2:0] op, input logic [31:0] b,
                    input bit push, input logic [31:0] exp);
    start  = 1'b1;
    ciN    = id;
    valueA = {29'd0, op};
    valueB = b;
    @(posedge clock); #1;
    start  = 1'b0;
    ciN    = 8'h00;
    valueA = '0;
    valueB = '0;
    if (push) exp_q.push_back(exp);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] b, input logic [31:0] exp);
    ci(ID, op, b, 1'b1, exp);
  endtask

  task automatic wait_done(input int budget, output int seen_at);
    seen_at = -1;
    for (int i = 0; i < budget && seen_at < 0; i++) begin
      @(negedge clock);
      if (done) seen_at = cyc;
    end
  endtask

  initial begin
    int g;
    int t;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_done", {31'd0, done}, 32'h0);
    chk("reset_result", result, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    do_op(3'd3, 0, 32'h0000_0000);
    do_op(3'd0, 0, 32'h0);

    // 10-cycle window, all counters enabled, quiet events, blocking WAIT
    do_op(3'd1, 10, 32'd0);
    do_op(3'd2, 4'hF, 32'd0);
    g = cyc;
    do_op(3'd5, 0, 32'd10);
    ci(ID, 3'd0, 0, 1'b0, 32'h0);
    wait_done(60, t);
    chk("wait_latency", (t < 0) ? 32'hFFFF_FFFF : 32'(t - g), 32'd10);
    do_op(3'd0, 1, 32'd0);
    do_op(3'd0, 2, 32'd0);
    do_op(3'd0, 3, 32'd0);
    do_op(3'd0, 0, 32'd10);
    do_op(3'd3, 0, 32'h8000_0000);

    // stall-only window with masked counters; stall also high on the GO cycle
    do_op(3'd1, 8, 32'd10);
    stall = 1'b1;
    do_op(3'd2, 4'b0110, 32'd0);
    repeat (12) @(posedge clock); #1;
    do_op(3'd0, 0, 32'd0);
    do_op(3'd0, 1, 32'd8);
    do_op(3'd0, 2, 32'd0);
    do_op(3'd0, 3, 32'd0);

    // stall and busIdle together: c3 stays 0
    busIdle = 1'b1;
    do_op(3'd1, 5, 32'd8);
    do_op(3'd2, 4'hF, 32'd0);
    repeat (8) @(posedge clock); #1;
    stall = 1'b0;
    busIdle = 1'b0;
    do_op(3'd0, 0, 32'd5);
    do_op(3'd0, 1, 32'd5);
    do_op(3'd0, 2, 32'd5);
    do_op(3'd0, 3, 32'd0);

    // ABORT after 20 counted cycles
    do_op(3'd1, 100, 32'd5);
    do_op(3'd2, 4'hF, 32'd0);
    repeat (20) @(posedge clock); #1;
    do_op(3'd4, 0, 32'd80);
    do_op(3'd3, 0, 32'hA000_0000);
    do_op(3'd0, 0, 32'd20);

    // zero-length window finishes immediately
    do_op(3'd1, 0, 32'd100);
    do_op(3'd2, 4'hF, 32'd0);
    do_op(3'd3, 0, 32'h8000_0000);
    do_op(3'd5, 0, 32'd0);

    // reset mid-window with a WAIT outstanding
    do_op(3'd1, 50, 32'd0);
    do_op(3'd2, 4'hF, 32'd0);
    do_op(3'd3, 0, 32'h4000_0000);
    ci(ID, 3'd5, 0, 1'b0, 32'h0);
    repeat (26) @(posedge clock); #1;
    reset = 1'b0;
    #2;
    chk("async_reset_done", {31'd0, done}, 32'h0);
    chk("async_reset_result", result, 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clock); #1;
    reset = 1'b1;
    do_op(3'd3, 0, 32'h0);
    do_op(3'd0, 0, 32'h0);
    do_op(3'd0, 1, 32'h0);
    do_op(3'd0, 2, 32'h0);
    do_op(3'd0, 3, 32'h0);
    do_op(3'd1, 3, 32'd0);

    // counter0 wraps modulo 2^32
    do_op(3'd2, 4'h1, 32'd0);
    force dut.g_cnt[0].u_cnt.value = 32'hFFFF_FFFE;
    #1;
    release dut.g_cnt[0].u_cnt.value;
    repeat (5) @(posedge clock); #1;
    do_op(3'd0, 0, 32'h1);
    do_op(3'd0, 1, 32'h0);

    // ABORT ends a pending WAIT with the frozen count (6 counted cycles)
    do_op(3'd1, 30, 32'd3);
    do_op(3'd2, 4'hF, 32'd0);
    do_op(3'd5, 0, 32'd6);
    repeat (5) @(posedge clock); #1;
    ci(ID, 3'd4, 0, 1'b0, 32'h0);
    wait_done(5, t);
    chk("abort_releases_wait", (t < 0) ? 32'h0 : 32'h1, 32'h1);
    do_op(3'd3, 0, 32'hA000_0000);
    do_op(3'd4, 0, 32'd24);
    do_op(3'd3, 0, 32'hA000_0000);

    // non-matching ciN, start low, and undefined opcodes
    ci(8'h05, 3'd0, 0, 1'b0, 32'h0);
    @(negedge clock);
    chk("wrong_cin_no_done", {31'd0, done}, 32'h0);
    valueA = 32'd3;
    ciN = ID;
    @(posedge clock); #1;
    @(negedge clock);
    chk("start_low_no_done", {31'd0, done}, 32'h0);
    do_op(3'd6, 32'hFFFF_FFFF, 32'h0);
    do_op(3'd7, 32'hFFFF_FFFF, 32'h0);
    do_op(3'd3, 0, 32'hA000_0000);

    repeat (4) @(posedge clock); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
